// File: rtl/gesummv_pkg.sv
// gesummv_pkg -- shared definitions for the GESUMMV engine.
//   * FSM state encoding (IDLE, LOAD_X, ACC, SCALE, OUT)
//   * calc_aw / calc_ow: accumulator and result widths derived from N and DW
package gesummv_pkg;

  typedef logic [2:0] state_t;

  localparam state_t S_IDLE   = 3'd0;
  localparam state_t S_LOAD_X = 3'd1;
  localparam state_t S_ACC    = 3'd2;
  localparam state_t S_SCALE  = 3'd3;
  localparam state_t S_OUT    = 3'd4;

  // A row sum of N products of two DW-bit operands never exceeds this width.
  function automatic int calc_aw(input int n, input int dw);
    return 2 * dw + $clog2(n);
  endfunction

  // alpha*acc_a + beta*acc_b: one more DW factor plus one carry bit.
  function automatic int calc_ow(input int n, input int dw);
    return 3 * dw + $clog2(n) + 1;
  endfunction

endpackage

// File: rtl/gesummv_mac.sv
// gesummv_mac -- one unsigned multiply-accumulate lane.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   clr        : synchronous clear of the accumulator (wins over en)
//   en         : add a*b to the accumulator this cycle
//   a, b       : DW-bit unsigned operands
//   acc        : AW-bit running sum
module gesummv_mac #(
  parameter int DW = 4,
  parameter int AW = 10
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr,
  input  logic          en,
  input  logic [DW-1:0] a,
  input  logic [DW-1:0] b,
  output logic [AW-1:0] acc
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc <= '0;
    end else if (clr) begin
      acc <= '0;
    end else if (en) begin
      acc <= acc + (AW'(a) * AW'(b));
    end
  end

endmodule

// File: rtl/gesummv_engine.sv
// gesummv_engine -- computes y = alpha*A*x + beta*B*x one row at a time.
// Ports:
//   clk, rst_n          : clock, asynchronous active-low reset
//   start, alpha, beta  : begin an operation (IDLE only), scalar coefficients
//   x_valid/x_ready/x_data            : x-vector load, index 0 first
//   ab_valid/ab_ready/a_data/b_data   : A and B elements, row-major
//   y_valid/y_ready/y_data            : one full-precision result per row
//   busy                : high whenever not IDLE
//   done                : one-cycle pulse after the last y is accepted
module gesummv_engine
  import gesummv_pkg::*;
#(
  parameter  int N  = 4,
  parameter  int DW = 4,
  localparam int OW = calc_ow(N, DW)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [DW-1:0] alpha,
  input  logic [DW-1:0] beta,
  input  logic          x_valid,
  output logic          x_ready,
  input  logic [DW-1:0] x_data,
  input  logic          ab_valid,
  output logic          ab_ready,
  input  logic [DW-1:0] a_data,
  input  logic [DW-1:0] b_data,
  output logic          y_valid,
  input  logic          y_ready,
  output logic [OW-1:0] y_data,
  output logic          busy,
  output logic          done
);

  localparam int AW = calc_aw(N, DW);
  localparam int IW = $clog2(N);
  localparam logic [IW-1:0] LAST = IW'(N - 1);

  state_t          state;
  logic [DW-1:0]   alpha_r;
  logic [DW-1:0]   beta_r;
  logic [DW-1:0]   x_buf [N];
  logic [IW-1:0]   idx;
  logic [IW-1:0]   col;
  logic [IW-1:0]   row;
  logic [AW-1:0]   acc_a;
  logic [AW-1:0]   acc_b;
  logic            acc_clr;
  logic            acc_en;

  // Handshake readiness is purely a function of state, so reset drives it to 0.
  assign x_ready  = (state == S_LOAD_X);
  assign ab_ready = (state == S_ACC);
  assign y_valid  = (state == S_OUT);
  assign busy     = (state != S_IDLE);

  // Accumulators restart on an accepted start and after each row is scaled.
  assign acc_clr = ((state == S_IDLE) && start) || (state == S_SCALE);
  assign acc_en  = ab_ready && ab_valid;

  gesummv_mac #(.DW(DW), .AW(AW)) u_mac_a (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (acc_clr),
    .en    (acc_en),
    .a     (a_data),
    .b     (x_buf[col]),
    .acc   (acc_a)
  );

  gesummv_mac #(.DW(DW), .AW(AW)) u_mac_b (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (acc_clr),
    .en    (acc_en),
    .a     (b_data),
    .b     (x_buf[col]),
    .acc   (acc_b)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      alpha_r <= '0;
      beta_r  <= '0;
      idx     <= '0;
      col     <= '0;
      row     <= '0;
      y_data  <= '0;
      done    <= 1'b0;
      for (int i = 0; i < N; i++) begin
        x_buf[i] <= '0;
      end
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            alpha_r <= alpha;
            beta_r  <= beta;
            idx     <= '0;
            col     <= '0;
            row     <= '0;
            state   <= S_LOAD_X;
          end
        end
        S_LOAD_X: begin
          if (x_valid) begin
            x_buf[idx] <= x_data;
            if (idx == LAST) begin
              idx   <= '0;
              state <= S_ACC;
            end else begin
              idx <= idx + 1'b1;
            end
          end
        end
        S_ACC: begin
          if (ab_valid) begin
            if (col == LAST) begin
              col   <= '0;
              state <= S_SCALE;
            end else begin
              col <= col + 1'b1;
            end
          end
        end
        S_SCALE: begin
          // Accumulators hold the complete row sums here; widen before scaling.
          y_data <= OW'(alpha_r) * OW'(acc_a) + OW'(beta_r) * OW'(acc_b);
          state  <= S_OUT;
        end
        S_OUT: begin
          if (y_ready) begin
            if (row == LAST) begin
              row   <= '0;
              done  <= 1'b1;
              state <= S_IDLE;
            end else begin
              row   <= row + 1'b1;
              state <= S_ACC;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_gesummv_engine.sv
// Testbench for gesummv_engine: directed runs with hand-computed row results,
// a scoreboard queue filled by the stimulus and drained by a y monitor.
module tb_gesummv_engine;

  localparam int N  = 4;
  localparam int DW = 4;
  localparam int OW = 15;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic [DW-1:0] alpha, beta;
  logic          x_valid;
  logic          x_ready;
  logic [DW-1:0] x_data;
  logic          ab_valid;
  logic          ab_ready;
  logic [DW-1:0] a_data, b_data;
  logic          y_valid;
  logic          y_ready;
  logic [OW-1:0] y_data;
  logic          busy;
  logic          done;

  int tests  = 0;
  int failed = 0;
  int exp_q[$];
  int cur_x[N];
  int cur_e[N];

  always #5 clk = ~clk;

  gesummv_engine #(.N(N), .DW(DW)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .alpha    (alpha),
    .beta     (beta),
    .x_valid  (x_valid),
    .x_ready  (x_ready),
    .x_data   (x_data),
    .ab_valid (ab_valid),
    .ab_ready (ab_ready),
    .a_data   (a_data),
    .b_data   (b_data),
    .y_valid  (y_valid),
    .y_ready  (y_ready),
    .y_data   (y_data),
    .busy     (busy),
    .done     (done)
  );

  task automatic check(input string name, input longint act, input longint exp);
    tests++;
    if (act != exp) begin
      failed++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard monitor: every accepted y must match the oldest expectation.
  always @(negedge clk) begin
    if (rst_n && y_valid && y_ready) begin
      if (exp_q.size() == 0) begin
        check("y_unexpected", longint'(y_data), -1);
      end else begin
        check("y_data", longint'(y_data), exp_q.pop_front());
      end
    end
  end

  task automatic set_vec(input int x0, x1, x2, x3, e0, e1, e2, e3);
    cur_x[0] = x0; cur_x[1] = x1; cur_x[2] = x2; cur_x[3] = x3;
    cur_e[0] = e0; cur_e[1] = e1; cur_e[2] = e2; cur_e[3] = e3;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_x_ready"}, x_ready, 0);
    check({tag, "_ab_ready"}, ab_ready, 0);
    check({tag, "_y_valid"}, y_valid, 0);
    check({tag, "_y_data"}, longint'(y_data), 0);
    check({tag, "_done"}, done, 0);
  endtask

  // Hold valid until ready is seen at a negedge; the following posedge accepts.
  task automatic beat(input bit is_x);
    bit ok = 1'b0;
    int n = 0;
    while (!ok && n < 200) begin
      @(negedge clk);
      ok = is_x ? x_ready : ab_ready;
      @(posedge clk);
      #1;
      n++;
    end
    if (!ok) check(is_x ? "x_beat_timeout" : "ab_beat_timeout", 0, 1);
  endtask

  task automatic do_start(input int al, input int be);
    alpha = DW'(al);
    beta  = DW'(be);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic load_x(input bit gaps);
    for (int i = 0; i < N; i++) begin
      if (gaps && $urandom_range(0, 1) == 1) begin
        x_valid = 1'b0;
        repeat ($urandom_range(1, 3)) @(posedge clk);
        #1;
      end
      x_valid = 1'b1;
      x_data  = DW'(cur_x[i]);
      beat(1'b1);
    end
    x_valid = 1'b0;
  endtask

  task automatic drive_ab(input int mode, input bit gaps, input bit poke, input int nbeats);
    int k = 0;
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
        if (k >= nbeats) return;
        if (gaps && $urandom_range(0, 2) == 0) begin
          ab_valid = 1'b0;
          repeat ($urandom_range(1, 3)) @(posedge clk);
          #1;
        end
        ab_valid = 1'b1;
        a_data   = (mode == 1) ? DW'(15) : DW'(i + j);
        b_data   = (mode == 1) ? DW'(15) : DW'(i + j + 1);
        if (poke && k == 6) begin
          start = 1'b1;
          alpha = '0;
          beta  = '0;
        end
        beat(1'b0);
        start = 1'b0;
        k++;
        if (j == N - 1) begin
          ab_valid = 1'b0;
          @(negedge clk);
          check("lat_scale_y_valid", y_valid, 0);
          @(negedge clk);
          check("lat_out_y_valid", y_valid, 1);
        end
      end
    end
    ab_valid = 1'b0;
  endtask

  task automatic ctrl_y(input int hold, input int nrows);
    y_ready = (hold == 0) ? 1'b0 : 1'b1;
    for (int r = 0; r < nrows; r++) begin
      bit seen = 1'b0;
      int n = 0;
      while (!seen && n < 300) begin
        @(negedge clk);
        seen = y_valid;
        n++;
      end
      if (!seen) begin
        check("y_valid_timeout", 0, 1);
        return;
      end
      if (r == hold) begin
        repeat (5) begin
          @(negedge clk);
          check("hold_y_data", longint'(y_data), cur_e[r]);
          check("hold_y_valid", y_valid, 1);
          check("hold_ab_ready", ab_ready, 0);
        end
        @(posedge clk);
        #1;
        y_ready = 1'b1;
      end
      @(posedge clk);
      #1;
      y_ready = (r + 1 == hold) ? 1'b0 : 1'b1;
    end
  endtask

  task automatic wait_done();
    bit seen = 1'b0;
    int n = 0;
    while (!seen && n < 50) begin
      @(negedge clk);
      seen = done;
      n++;
    end
    check("done_pulse", seen, 1);
    @(negedge clk);
    check("done_cleared", done, 0);
    check("idle_busy", busy, 0);
    @(posedge clk);
    #1;
  endtask

  task automatic body(input int mode, input bit gaps, input int hold, input bit poke);
    load_x(gaps);
    fork
      drive_ab(mode, gaps, poke, N * N);
      ctrl_y(hold, N);
    join
    wait_done();
  endtask

  task automatic run(input int al, input int be, input int mode, input bit gaps,
                     input int hold, input bit poke);
    for (int i = 0; i < N; i++) exp_q.push_back(cur_e[i]);
    do_start(al, be);
    check("busy_after_start", busy, 1);
    body(mode, gaps, hold, poke);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; alpha = '0; beta = '0;
    x_valid = 1'b0; x_data = '0; ab_valid = 1'b0; a_data = '0; b_data = '0;
    y_ready = 1'b1;
    #1;
    check_all_zero("reset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Baseline: alpha=beta=11, x={0,1,2,3}, A=i+j, B=i+j+1.
    set_vec(0, 1, 2, 3, 374, 506, 638, 770);
    run(11, 11, 0, 1'b0, -1, 1'b0);

    // Output back-pressure on row 1.
    run(11, 11, 0, 1'b0, 1, 1'b0);

    // Idle beats on both input streams.
    run(11, 11, 0, 1'b1, -1, 1'b0);

    // Full-scale operands: 15*(4*225)*2 = 27000.
    set_vec(15, 15, 15, 15, 27000, 27000, 27000, 27000);
    run(15, 15, 1, 1'b0, -1, 1'b0);

    // Distinct coefficients, x all ones overwrites the previous x: 20*i + 42.
    set_vec(1, 1, 1, 1, 42, 62, 82, 102);
    run(2, 3, 0, 1'b0, -1, 1'b0);

    // start with garbage coefficients during ACC must be ignored.
    set_vec(0, 1, 2, 3, 374, 506, 638, 770);
    run(11, 11, 0, 1'b0, -1, 1'b1);

    // Reset two beats into row 2; only rows 0 and 1 are ever expected.
    exp_q.push_back(374);
    exp_q.push_back(506);
    do_start(11, 11);
    load_x(1'b0);
    fork
      drive_ab(0, 1'b0, 1'b0, 2 * N + 2);
      ctrl_y(-1, 2);
    join
    check("pre_rst_busy", busy, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check_all_zero("mid_rst");
    ab_valid = 1'b1;
    repeat (2) @(negedge clk);
    check_all_zero("held_rst");
    ab_valid = 1'b0;
    alpha = DW'(11);
    beta  = DW'(11);
    start = 1'b1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    check("first_edge_start_busy", busy, 1);
    check("first_edge_start_x_ready", x_ready, 1);
    check("sb_after_rst_empty", exp_q.size(), 0);
    for (int i = 0; i < N; i++) exp_q.push_back(cur_e[i]);
    body(0, 1'b0, -1, 1'b0);

    repeat (3) @(negedge clk);
    check("sb_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

  // Global guard so the bench always terminates.
  initial begin
    #200000;
    $display("FAIL global_timeout: got 0 expected 1");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/gesummv_engine.md
GESUMMV_ENGINE -- requirements
Module: gesummv_engine

Interface
REQ-001 Parameter N, default 4: matrix dimension and vector length; legal values are N >= 2.
REQ-002 Parameter DW, default 4: width of every unsigned input operand; legal values are DW >= 2.
REQ-003 Derived OW = 3*DW + clog2(N) + 1: full-precision result width; no truncation anywhere.
REQ-004 clk  in  1  single clock; all state changes on its rising edge.
REQ-005 rst_n  in  1  asynchronous, active-low reset.
REQ-006 start  in  1  single-cycle pulse that begins an operation; sampled only in IDLE.
REQ-007 alpha, beta  in  DW each  scalar coefficients, captured when start is accepted.
REQ-008 x_valid / x_ready  in / out  1 each  handshake for the x-vector load.
REQ-009 x_data  in  DW  one x element per accepted beat, index 0 first.
REQ-010 ab_valid / ab_ready  in / out  1 each  handshake for the matrix-element stream.
REQ-011 a_data, b_data  in  DW each  A[i][j] and B[i][j], row-major order.
REQ-012 y_valid / y_ready  out / in  1 each  handshake for results.
REQ-013 y_data  out  OW  y[i] = alpha*sum_j(A[i][j]*x[j]) + beta*sum_j(B[i][j]*x[j]).
REQ-014 busy  out  1  high in every state except IDLE.
REQ-015 done  out  1  one-cycle pulse after the last y is accepted.

Function
REQ-016 The FSM shall have five states: IDLE, LOAD_X, ACC, SCALE and OUT.
REQ-017 IDLE -> LOAD_X on start; the block shall capture alpha and beta, clear the indices and clear both accumulators.
REQ-018 LOAD_X: x_ready shall be 1; each beat (x_valid & x_ready) shall write x_buf[idx]; after N beats the block shall move to ACC.
REQ-019 ACC: ab_ready shall be 1; each beat shall add a_data*x_buf[col] to acc_a and b_data*x_buf[col] to acc_b, then advance col.
REQ-020 When the beat with col = N-1 is accepted, col shall wrap to 0 and the block shall move to SCALE.
REQ-021 SCALE shall last exactly one cycle: it shall register y = alpha*acc_a + beta*acc_b, clear both accumulators and move to OUT.
REQ-022 OUT: y_valid shall be 1 and y_data shall stay stable until y_ready is sampled high.
REQ-023 On the y handshake, the block shall increment row; if row was N-1 it shall go to IDLE and pulse done, otherwise it shall return to ACC.
REQ-024 Latency: y_valid shall rise exactly 2 clk edges after the edge that accepts the last element of a row.
REQ-025 x_ready and ab_ready shall be 0 outside LOAD_X and ACC respectively; data presented while ready is low shall be ignored.
REQ-026 start asserted while busy shall be ignored, with no effect on state or data.
REQ-027 Idle cycles (valid low) inside LOAD_X or ACC shall not change any index or accumulator.
REQ-028 x_buf shall be retained for all N rows; a new start shall overwrite it completely.
REQ-029 All arithmetic shall be unsigned; accumulators are 2*DW + clog2(N) bits wide; sums shall never wrap for any legal input.

Reset
REQ-030 rst_n low shall immediately force state to IDLE, regardless of the current state.
REQ-031 While rst_n is low, every output shall be 0, and so shall all indices, accumulators, alpha/beta registers and x_buf.
REQ-032 A reset mid-operation shall discard the partial result; no y_valid or done shall follow it.
REQ-033 The first start shall be accepted on the first rising edge at which rst_n is high.

Structure
REQ-034 Package gesummv_pkg shall hold the state enumeration and a function that computes OW from N and DW.
REQ-035 Sub-module gesummv_mac (one multiply-accumulate lane with clear and enable) shall be instantiated twice, once for the A path and once for the B path.

Verification
REQ-036 Default parameters, alpha = beta = 11, x = {0,1,2,3}, A[i][j] = i+j, B[i][j] = i+j+1 -> y = 374, 506, 638, 770, followed by a done pulse.
REQ-037 The same stimulus with y_ready held low for 5 cycles on row 1 -> y_data is stable at 506, ab_ready stays 0 and no element is lost.
REQ-038 Random deassertion of x_valid and ab_valid -> results are identical to REQ-036.
REQ-039 All inputs at 15, alpha = beta = 15 -> every y = 27000, with no overflow.
REQ-040 rst_n pulsed low during ACC of row 2 -> all outputs go to 0 at once; a fresh run afterwards matches REQ-036.
REQ-041 start pulsed during ACC -> ignored; the current run completes unchanged.
